// File: rtl/led7seg_pkg.sv
// Shared types and constants for the seven-segment decoder.
// All segment patterns are stored in active-low (common-anode) form, bit 6 = a.
package led7seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F_IDX = 1;
    localparam int SEG_G = 0;

    localparam seg7_t SEG_0     = 7'b0000001;
    localparam seg7_t SEG_1     = 7'b1001111;
    localparam seg7_t SEG_2     = 7'b0010010;
    localparam seg7_t SEG_3     = 7'b0000110;
    localparam seg7_t SEG_4     = 7'b1001100;
    localparam seg7_t SEG_5     = 7'b0100100;
    localparam seg7_t SEG_6     = 7'b0100000;
    localparam seg7_t SEG_7     = 7'b0001111;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0000100;
    localparam seg7_t SEG_A_HEX = 7'b0001000;
    localparam seg7_t SEG_B_HEX = 7'b1100000;
    localparam seg7_t SEG_C_HEX = 7'b0110001;
    localparam seg7_t SEG_D_HEX = 7'b1000010;
    localparam seg7_t SEG_E_HEX = 7'b0110000;
    localparam seg7_t SEG_F     = 7'b0111000;
    localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_rom.sv
// Combinational nibble -> active-low segment lookup.
// Define LED7SEG_HEX_EN to show A..F for codes 10-15; otherwise they are dark.
module seg7_rom
    import led7seg_pkg::*;
(
    input  logic [3:0] x,
    output seg7_t      seg
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives seg and no latch is inferred.
        seg = SEG_BLANK;
        case (x)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
`ifdef LED7SEG_HEX_EN
            4'hA: seg = SEG_A_HEX;
            4'hB: seg = SEG_B_HEX;
            4'hC: seg = SEG_C_HEX;
            4'hD: seg = SEG_D_HEX;
            4'hE: seg = SEG_E_HEX;
            4'hF: seg = SEG_F;
`else
            default: seg = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/led7seg_decoder.sv
// Registered hex-to-seven-segment decoder with blanking, decimal point and selectable polarity.
// Codes 10-15 show A..F only when LED7SEG_HEX_EN is defined.
module led7seg_decoder
    import led7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] x,
    input  logic       blank,
    input  logic       dp_in,
    output logic [6:0] a_to_g,
    output logic       dp
);

    // XOR masks turn the active-low patterns into the configured polarity, reset/blank included.
    localparam seg7_t SEG_MASK = ACTIVE_LOW ? 7'b0000000 : 7'b1111111;
    localparam logic  DP_MASK  = ACTIVE_LOW ? 1'b0 : 1'b1;

    seg7_t rom_seg;
    seg7_t seg_low;
    logic  dp_low;

    seg7_rom u_rom (
        .x   (x),
        .seg (rom_seg)
    );

    always_comb begin
        seg_low = blank ? SEG_BLANK : rom_seg;
        dp_low  = ~(dp_in & ~blank);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            a_to_g <= SEG_BLANK ^ SEG_MASK;
            dp     <= 1'b1 ^ DP_MASK;
        end else begin
            a_to_g <= seg_low ^ SEG_MASK;
            dp     <= dp_low ^ DP_MASK;
        end
    end

endmodule

// File: tb/tb_led7seg_decoder.sv
// Scoreboard bench: drives both polarities of led7seg_decoder from shared inputs and
// compares each registered output against an independent table model.
module tb_led7seg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x;
    logic       blank;
    logic       dp_in;
    logic [6:0] a_to_g;
    logic       dp;
    logic [6:0] a_to_g_inv;
    logic       dp_inv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] low;   // {a_to_g, dp} in active-low form
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] tbl [16];

    always #5 clk = ~clk;

    led7seg_decoder #(.ACTIVE_LOW(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .blank  (blank),
        .dp_in  (dp_in),
        .a_to_g (a_to_g),
        .dp     (dp)
    );

    led7seg_decoder #(.ACTIVE_LOW(1'b0)) dut_inv (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .blank  (blank),
        .dp_in  (dp_in),
        .a_to_g (a_to_g_inv),
        .dp     (dp_inv)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model(input logic r, input logic [3:0] v, input logic b, input logic d);
        if (r || b) return 8'hFF;
        return {tbl[v], ~d};
    endfunction

    // Drive one input set, queue its expectation, then check after the edge and again mid-cycle.
    task automatic step(input logic r, input logic [3:0] v, input logic b, input logic d, input string tag);
        exp_t e;
        rst   = r;
        x     = v;
        blank = b;
        dp_in = d;
        exp_q.push_back('{low: model(r, v, b, d), tag: tag});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, {a_to_g, dp}, e.low);
            check({e.tag, "_inv"}, {a_to_g_inv, dp_inv}, ~e.low);
            @(negedge clk);
            check({e.tag, "_hold"}, {a_to_g, dp}, e.low);
        end
    endtask

    initial begin
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100,
`ifdef LED7SEG_HEX_EN
                7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`else
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
`endif

        // Reset held with x=8, then release
        for (int i = 0; i < 3; i++) step(1'b1, 4'h8, 1'b0, 1'b0, $sformatf("reset%0d", i));
        step(1'b0, 4'h8, 1'b0, 1'b0, "reset_release");

        // Exhaustive sweep, dp toggling
        for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 1'(i % 2), $sformatf("sweep_x%0d", i));

        // Back-to-back latency
        step(1'b0, 4'h1, 1'b0, 1'b0, "latency_x1");
        step(1'b0, 4'h2, 1'b0, 1'b0, "latency_x2");

        // Blank overrides digit and dp, then release
        step(1'b0, 4'h0, 1'b1, 1'b1, "blank_on");
        step(1'b0, 4'h0, 1'b0, 1'b1, "blank_off");

        // Polarity spot check: x=3 (inverted instance expects 1111001)
        step(1'b0, 4'h3, 1'b0, 1'b0, "polarity_x3");

        // Mid-stream reset at x=5
        for (int i = 0; i < 10; i++)
            step(i == 5, 4'(i), 1'b0, 1'(i == 7), $sformatf("midrst_x%0d", i));

        // Reset beats blank and dp
        step(1'b1, 4'h6, 1'b1, 1'b1, "rst_over_blank");
        step(1'b0, 4'h6, 1'b0, 1'b1, "after_rst");

        check("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
